operand_loader: RTL

Front-end sequencer for the 4-bit add/subtract datapath. It turns a bank of slide switches and two raw pushbuttons into registered operands `a0`, `a1` and operation select `s`, entered one at a time. It drives the adder/subtractor and display decoder stage directly. Buttons are synchronized and debounced, and the entry flow is a small state machine, so the downstream stage only sees clean, stable values.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/button_debounce.sv | 61 ++++++
 rtl/operand_loader.sv | 88 ++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// +--------------------------------------------------------------------+
// | calc_pkg: shared entry-state encoding and debounce default.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package calc_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DEBOUNCE_DEFAULT = 500000;

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// +--------------------------------------------------------------------+
// | button_debounce: 2-flop sync, debounce counter, rising-edge pulse.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module button_debounce
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int                c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // Any cycle where the synchronized level agrees restarts the count.
            if (r_sync2 != r_level) begin
                if (r_cnt == c_cnt_last) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/operand_loader.sv
// +--------------------------------------------------------------------+
// | operand_loader: debounced button-driven entry of a0, a1 and s.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module operand_loader
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       sw_op,
    input  logic       btn_load,
    input  logic       btn_clear,
    output logic [3:0] a0,
    output logic [3:0] a1,
    output logic       s,
    output logic       valid,
    output logic [1:0] phase
);

    logic       w_load_press;
    logic       w_clear_press;
    state_t     r_state;
    logic [3:0] r_a0;
    logic [3:0] r_a1;
    logic       r_s;
    logic       r_valid;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_load),
        .level (),
        .press (w_load_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_clear),
        .level (),
        .press (w_clear_press)
    );

    always_ff @(posedge clk) begin
        if (reset || w_clear_press) begin
            // Clear shares the reset path so it always beats a same-cycle load.
            r_state <= LOAD_A;
            r_a0    <= 4'd0;
            r_a1    <= 4'd0;
            r_s     <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_load_press) begin
            case (r_state)
                LOAD_A: begin
                    r_a0    <= sw;
                    r_state <= LOAD_B;
                end
                LOAD_B: begin
                    r_a1    <= sw;
                    r_state <= LOAD_OP;
                end
                LOAD_OP: begin
                    r_s     <= sw_op;
                    r_valid <= 1'b1;
                    r_state <= DONE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= LOAD_A;
                end
            endcase
        end
    end

    assign a0    = r_a0;
    assign a1    = r_a1;
    assign s     = r_s;
    assign valid = r_valid;
    assign phase = r_state;

endmodule

`default_nettype wire
